gf180_ram_128x8_ctrl: RTL and testbench
=======================================

# gf180_ram_128x8_ctrl

Request/response front end for the 128x8 GF180 SRAM wrapper. It sits directly upstream of the SRAM macro wrapper and turns a valid/ready byte-access port into the macro's active-low CEN/GWEN/WEN strobes. It registers read data into a 2-entry response FIFO with backpressure. After reset it optionally zero-fills the whole array before accepting traffic.

## Interface
Parameters:
- CLEAR_ON_RESET, 1, when 1 the block runs a 128-cycle array fill after reset; when 0 it goes straight to RUN.
- CLEAR_VALUE, 8'h00, byte written to every address during the fill.

Ports. One clock, `CLK`. Reset `RST` is asynchronous and active-high.
- CLK  in  1  clock; also drives the SRAM macro's CLK.
- RST  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on the rising CLK edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  7  byte address.
- req_wdata  in  8  write data.
- req_wmask  in  8  active-high per-bit write mask.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response on a rising edge where rsp_valid && rsp_ready.
- rsp_rdata  out  8  read data.
- init_done  out  1  1 once in RUN; held until reset.
- ram_cen  out  1  to SRAM CEN, active low.
- ram_gwen  out  1  to SRAM GWEN, active low (0 = write).
- ram_wen  out  8  to SRAM WEN, active-low bit mask.
- ram_a  out  7  to SRAM A.
- ram_d  out  8  to SRAM D.
- ram_q  in  8  from SRAM Q.

## Operation
- States:
  - INIT: array fill.
  - RUN: normal operation.
- Reset and state entry:
  - RST sends the block to INIT if CLEAR_ON_RESET, else to RUN.
  - No other transitions.
- INIT:
  - A 7-bit counter `clr_addr` starts at 0.
  - Each cycle drives ram_cen=0, ram_gwen=0, ram_wen=8'h00, ram_a=clr_addr, ram_d=CLEAR_VALUE.
  - After the edge that writes address 127, the block enters RUN.
  - req_ready=0 throughout INIT.
- RUN, access issue (combinational from the request port):
  - An access fires when req_valid && req_ready.
  - ram_cen=0.
  - ram_gwen = !req_we.
  - ram_wen = req_we ? ~req_wmask : 8'hFF.
  - ram_a = req_addr.
  - ram_d = req_wdata.
  - The SRAM samples the access on the same edge as the handshake.
- RUN, no access:
  - ram_cen=1, ram_gwen=1, ram_wen=8'hFF, ram_a=0, ram_d=0.
- Read data path:
  - An accepted read sets `rd_pend`.
  - On the next edge, ram_q is pushed into the 2-entry response FIFO and rd_pend clears, unless another read is accepted on that edge.
  - Writes produce no response.
- Credit rule: req_ready = (state==RUN) && (rd_pend + fifo_cnt − pop) < 2, where pop = rsp_valid && rsp_ready.
  - req_ready does not depend on req_we.
  - A write with req_wmask=0 still consumes a cycle and changes no bits.
- Response FIFO:
  - rsp_valid = fifo_cnt != 0.
  - rsp_rdata = head entry.
  - Push and pop on the same edge are both honoured.
  - The credit rule guarantees the FIFO never overflows. Any push while full is an assertion failure.
- init_done = (state==RUN).

## Timing
- Read latency: request accepted at edge E0; rsp_valid=1 with data after edge E1.
- Throughput:
  - One read per cycle sustained while rsp_ready=1.
  - One write per cycle always in RUN.
- Backpressure:
  - With rsp_ready=0, at most 2 reads are outstanding.
  - req_ready drops after the second read is accepted.
- Read-after-write to the same address on consecutive edges returns the new data.
- INIT takes 128 cycles. With CLEAR_ON_RESET=1, init_done and req_ready first rise after the 128th edge following RST deassertion.
- Reset values, forced while RST=1:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - ram_cen=1, ram_gwen=1, ram_wen=8'hFF, ram_a=0, ram_d=0.
- Reset mid-operation:
  - Pending reads and FIFO contents are dropped.
  - clr_addr returns to 0.
  - An in-flight fill restarts from address 0.

## Structure
- Package `gf180_ram_pkg`:
  - RAM_AW=7, RAM_DW=8, RAM_DEPTH=128.
  - State enum {ST_INIT, ST_RUN}.
  - Response FIFO depth constant RSP_DEPTH=2.
- Sub-module `gf180_ram_rsp_fifo`:
  - 2-entry, width-parameterised, synchronous FIFO with push/pop/count.
  - Asynchronous active-high reset.
- Top-level wiring: the controller instantiates only the FIFO. The SRAM wrapper is connected beside it at the next level up.

## Test plan
- Reset fill:
  - Stimulus: CLEAR_ON_RESET=1, CLEAR_VALUE=8'hA5, release RST.
  - Required: exactly 128 writes to addresses 0..127 with ram_wen=8'h00; init_done rises after edge 128; a read of addr 7'h55 returns 8'hA5.
- Masked write:
  - Stimulus: write 8'hFF with mask 8'h0F to addr 3 (preloaded 8'h00), then read addr 3.
  - Required: ram_wen=8'hF0 on the write; rsp_rdata=8'h0F one edge after the read is accepted.
- Streaming reads:
  - Stimulus: rsp_ready=1, reads to addresses 0..15 on consecutive cycles.
  - Required: req_ready stays 1; 16 responses in order on consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready=0, req_valid held with reads.
  - Required: exactly 2 accepted, then req_ready=0; raise rsp_ready and both responses drain in order with no loss.
- Read-after-write:
  - Stimulus: write 8'h3C to addr 9 at edge N, read addr 9 at edge N+1.
  - Required: response 8'h3C.
- Reset mid-traffic:
  - Stimulus: assert RST with 2 reads outstanding.
  - Required: all outputs immediately at reset values; after release, INIT restarts at address 0 and no stale responses appear.

Source files
------------

// File: rtl/gf180_ram_pkg.sv
// Shared sizes and state encoding for the 128x8 GF180 SRAM front end.
package gf180_ram_pkg;

    localparam int RAM_AW    = 7;
    localparam int RAM_DW    = 8;
    localparam int RAM_DEPTH = 128;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_PTR_W = $clog2(RSP_DEPTH);
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/gf180_ram_rsp_fifo.sv
// Small synchronous response FIFO holding read data until the consumer takes it.
module gf180_ram_rsp_fifo
    import gf180_ram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata,
    output logic [RSP_CNT_W-1:0] o_count
);

    localparam logic [RSP_CNT_W-1:0] FULL_CNT = RSP_CNT_W'(RSP_DEPTH);

    logic [WIDTH-1:0]     r_mem [RSP_DEPTH];
    logic [RSP_PTR_W-1:0] r_wptr;
    logic [RSP_PTR_W-1:0] r_rptr;
    logic [RSP_CNT_W-1:0] r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign w_push_ok = i_push && (r_count != FULL_CNT);
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage is cleared on reset so the read port shows zero while empty after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            assert (!(i_push && (r_count == FULL_CNT)));
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + RSP_CNT_W'(w_push_ok) - RSP_CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/gf180_ram_128x8_ctrl.sv
// Valid/ready byte-access front end driving the GF180 128x8 SRAM strobes,
// with an optional post-reset array fill and a credit-limited read response path.
module gf180_ram_128x8_ctrl
    import gf180_ram_pkg::*;
#(
    parameter logic              CLEAR_ON_RESET = 1'b1,
    parameter logic [RAM_DW-1:0] CLEAR_VALUE    = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [RAM_AW-1:0] req_addr,
    input  logic [RAM_DW-1:0] req_wdata,
    input  logic [RAM_DW-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RAM_DW-1:0] rsp_rdata,
    output logic              init_done,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [RAM_DW-1:0] ram_wen,
    output logic [RAM_AW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_d,
    input  logic [RAM_DW-1:0] ram_q
);

    localparam state_t                RESET_STATE  = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [RAM_AW-1:0]     LAST_ADDR    = RAM_AW'(RAM_DEPTH - 1);
    localparam logic [RSP_CNT_W:0]    CREDIT_LIMIT = (RSP_CNT_W + 1)'(RSP_DEPTH);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [RAM_AW-1:0]      r_clr_addr;
    logic                   r_rd_pend;
    logic                   w_fire;
    logic                   w_rd_fire;
    logic                   w_pop;
    logic [RSP_CNT_W-1:0]   w_fifo_cnt;
    logic [RSP_CNT_W:0]     w_inflight;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_INIT) && (r_clr_addr == LAST_ADDR)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clr_addr <= '0;
            r_rd_pend  <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            r_rd_pend <= w_rd_fire;
        end
    end

    // A read in flight to the macro already owns a FIFO slot, so it counts against the credit.
    assign rsp_valid  = (w_fifo_cnt != '0);
    assign w_pop      = rsp_valid && rsp_ready;
    assign w_inflight = (RSP_CNT_W + 1)'(r_rd_pend) + (RSP_CNT_W + 1)'(w_fifo_cnt)
                      - (RSP_CNT_W + 1)'(w_pop);
    assign req_ready  = !RST && (r_state == ST_RUN) && (w_inflight < CREDIT_LIMIT);
    assign w_fire     = req_valid && req_ready;
    assign w_rd_fire  = w_fire && !req_we;
    assign init_done  = !RST && (r_state == ST_RUN);

    always_comb begin
        ram_cen  = 1'b1;
        ram_gwen = 1'b1;
        ram_wen  = '1;
        ram_a    = '0;
        ram_d    = '0;
        if (!RST) begin
            if (r_state == ST_INIT) begin
                ram_cen  = 1'b0;
                ram_gwen = 1'b0;
                ram_wen  = '0;
                ram_a    = r_clr_addr;
                ram_d    = CLEAR_VALUE;
            end else if (w_fire) begin
                ram_cen  = 1'b0;
                ram_gwen = !req_we;
                ram_wen  = req_we ? ~req_wmask : '1;
                ram_a    = req_addr;
                ram_d    = req_wdata;
            end
        end
    end

    gf180_ram_rsp_fifo #(
        .WIDTH (RAM_DW)
    ) u_rsp_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (r_rd_pend),
        .i_pop   (w_pop),
        .i_wdata (ram_q),
        .o_rdata (rsp_rdata),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_gf180_ram_128x8_ctrl.sv
// Scoreboard bench for gf180_ram_128x8_ctrl with a behavioural 128x8 SRAM beside it.
module tb_gf180_ram_128x8_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [7:0] req_wmask = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       ram_cen;
    logic       ram_gwen;
    logic [7:0] ram_wen;
    logic [6:0] ram_a;
    logic [7:0] ram_d;
    logic [7:0] ram_q = '0;

    logic [7:0] sramMem [128];
    logic [7:0] expQ [$];
    int nVectors = 0;
    int nMiscompares = 0;
    int waits;

    gf180_ram_128x8_ctrl #(
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    (8'hA5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wen   (ram_wen),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    always #5 CLK = ~CLK;

    // Macro model: bit-masked write, registered read data.
    always @(posedge CLK) begin
        if (!ram_cen) begin
            if (!ram_gwen) begin
                for (int b = 0; b < 8; b++) begin
                    if (!ram_wen[b]) sramMem[ram_a][b] <= ram_d[b];
                end
            end else begin
                ram_q <= sramMem[ram_a];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every response the consumer takes must match the oldest expected byte.
    always @(negedge CLK) begin
        if (!RST && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected rsp: got %0h, expected no response", rsp_rdata);
            end else begin
                checkOutput("rsp_rdata", rsp_rdata, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] wmask, input logic [7:0] expRdata, output int nWait);
        bit fired = 0;
        nWait = 0;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!fired && nWait < 20) begin
            #1;
            if (req_ready) begin
                fired = 1;
                checkOutput("access strobes", {ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
                            {1'b0, !we, (we ? ~wmask : 8'hFF), addr, wdata});
                if (!we) expQ.push_back(expRdata);
            end else begin
                nWait++;
            end
            @(posedge CLK);
            if (!fired) @(negedge CLK);
        end
        if (!fired) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL req accept timeout: waited %0d cycles, required acceptance", nWait);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string name);
        checkOutput(name, {req_ready, rsp_valid, rsp_rdata, init_done, ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
                    {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 7'h00, 8'h00});
    endtask

    task automatic checkFill();
        for (int k = 0; k < 128; k++) begin
            checkOutput("fill strobes", {init_done, req_ready, ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
                        {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'(k), 8'hA5});
            @(negedge CLK);
            #1;
        end
        checkOutput("init_done/req_ready after fill", {init_done, req_ready}, 2'b11);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkResetValues("reset values at start");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkFill();

        applyStimulus(1'b0, 7'h55, 8'h00, 8'h00, 8'hA5, waits);

        // Masked write on top of a known zero byte, then read back with latency check.
        applyStimulus(1'b1, 7'd3, 8'h00, 8'hFF, 8'h00, waits);
        applyStimulus(1'b1, 7'd3, 8'hFF, 8'h0F, 8'h00, waits);
        applyStimulus(1'b0, 7'd3, 8'h00, 8'h00, 8'h0F, waits);
        @(negedge CLK);
        checkOutput("rsp_valid before E1", rsp_valid, 1'b0);
        @(negedge CLK);
        checkOutput("rsp_valid after E1", rsp_valid, 1'b1);

        applyStimulus(1'b1, 7'd9, 8'h3C, 8'hFF, 8'h00, waits);
        applyStimulus(1'b0, 7'd9, 8'h00, 8'h00, 8'h3C, waits);
        checkOutput("raw read waits", waits, 0);
        repeat (4) @(posedge CLK);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 7'(i), 8'h00, 8'h00, (i == 3) ? 8'h0F : ((i == 9) ? 8'h3C : 8'hA5), waits);
            checkOutput("stream req_ready", waits, 0);
            if (i > 0) checkOutput("stream rsp_valid", rsp_valid, 1'b1);
        end

        applyStimulus(1'b1, 7'd20, 8'h11, 8'hFF, 8'h00, waits);
        applyStimulus(1'b1, 7'd21, 8'h22, 8'hFF, 8'h00, waits);
        applyStimulus(1'b1, 7'd22, 8'h33, 8'hFF, 8'h00, waits);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("stream drained", expQ.size(), 0);

        rsp_ready = 1'b0;
        applyStimulus(1'b0, 7'd20, 8'h00, 8'h00, 8'h11, waits);
        checkOutput("bp first read waits", waits, 0);
        applyStimulus(1'b0, 7'd21, 8'h00, 8'h00, 8'h22, waits);
        checkOutput("bp second read waits", waits, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'd22;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            checkOutput("bp req_ready/rsp_valid", {req_ready, rsp_valid}, 2'b01);
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 7'd22, 8'h00, 8'h00, 8'h33, waits);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("bp drained", expQ.size(), 0);

        // Reset with two reads outstanding: everything in flight is discarded.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 7'd20, 8'h00, 8'h00, 8'h11, waits);
        applyStimulus(1'b0, 7'd21, 8'h00, 8'h00, 8'h22, waits);
        RST = 1'b1;
        expQ.delete();
        #1;
        checkResetValues("reset values mid-traffic");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkFill();
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("no stale response", rsp_valid, 1'b0);
        applyStimulus(1'b0, 7'd20, 8'h00, 8'h00, 8'hA5, waits);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("final drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
